// File: rtl/mult_acc_simd.sv
// rtl/mult_acc_simd.sv - per-lane SIMD product accumulator with valid/ready output (optional ACC_SAT_EN saturation)
module mult_acc_simd #(
    parameter int PICTURE_NUM = 8,
    parameter int WIDTH_IN    = 20,
    parameter int WIDTH_ACC   = 32,
    parameter int LEN_W       = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [LEN_W-1:0]                 acc_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PICTURE_NUM*WIDTH_IN-1:0]  data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PICTURE_NUM*WIDTH_ACC-1:0] data_out,
    output logic                             busy,
    output logic                             ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [LEN_W-1:0]                 len_q, len_d;
    logic [LEN_W-1:0]                 cnt_q, cnt_d;
    logic [LEN_W-1:0]                 cnt_inc;
    logic [PICTURE_NUM*WIDTH_ACC-1:0] acc_q, acc_d;
    logic [PICTURE_NUM*WIDTH_ACC-1:0] dout_q, dout_d;
    logic                             out_valid_q, out_valid_d;
    logic [PICTURE_NUM*WIDTH_ACC-1:0] sum_w;
    logic [PICTURE_NUM-1:0]           clamp_w;
    logic signed [WIDTH_ACC-1:0]      lane_a, lane_x, lane_s;

    // Per-lane sign-extended add; the optional clamp replaces the wrapped result on signed overflow
    always_comb begin
        sum_w   = '0;
        clamp_w = '0;
        lane_a  = '0;
        lane_x  = '0;
        lane_s  = '0;
        for (int i = 0; i < PICTURE_NUM; i++) begin
            lane_a = acc_q[i*WIDTH_ACC +: WIDTH_ACC];
            lane_x = WIDTH_ACC'($signed(data_in[i*WIDTH_IN +: WIDTH_IN]));
            lane_s = lane_a + lane_x;
`ifdef ACC_SAT_EN
            if ((lane_a[WIDTH_ACC-1] == lane_x[WIDTH_ACC-1]) &&
                (lane_s[WIDTH_ACC-1] != lane_a[WIDTH_ACC-1])) begin
                clamp_w[i] = 1'b1;
                lane_s     = lane_a[WIDTH_ACC-1] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                                 : {1'b0, {(WIDTH_ACC-1){1'b1}}};
            end
`endif
            sum_w[i*WIDTH_ACC +: WIDTH_ACC] = lane_s;
        end
    end

    assign cnt_inc = cnt_q + LEN_W'(1);

    // Job sequencing: latch length on start, accumulate beats, park the result until handed off
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start && (acc_len != '0)) begin
                    len_d   = acc_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = sum_w;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        dout_d      = sum_w;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ACC_SAT_EN
    logic ovf_q, ovf_d;

    // Sticky clamp flag, cleared by an accepted start
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == S_IDLE) && start && (acc_len != '0)) begin
            ovf_d = 1'b0;
        end else if ((state_q == S_ACC) && in_valid) begin
            ovf_d = ovf_q | (|clamp_w);
        end
    end

    // Clamp flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state_q == S_ACC);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = dout_q;

endmodule
